reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 30 +++
 rtl/sync_bit.sv | 24 ++
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_reset_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encoding, default timing constants and counter sizing
// helpers for the board reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_PLL   = 3'd0,
        ST_WAIT_SDRAM = 3'd1,
        ST_HOLD       = 3'd2,
        ST_RUN        = 3'd3,
        ST_SOFT       = 3'd4
    } rs_state_e;

    localparam int unsigned DEF_HOLD_CYCLES    = 1024;
    localparam int unsigned DEF_SOFT_CYCLES    = 256;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 108_000_000;
    localparam int unsigned DEF_SYNC_STAGES    = 2;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    // A count of 1 still needs one flop to hold its zero value.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level input.
// All stages clear to 0 while reset is asserted.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: waits for PLL lock and SDRAM init, holds reset,
// then releases RESET_OUT_n; supports timed soft resets and a timeout flag.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned SOFT_CYCLES    = DEF_SOFT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PLL_READY,
    input  logic       SDRAM_READY,
    input  logic       SOFT_RESET_REQ,
    output logic       RESET_OUT_n,
    output logic [2:0] STATE,
    output logic       TIMEOUT
);

    localparam int unsigned CW = cnt_width(max_u(HOLD_CYCLES, SOFT_CYCLES));
    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SOFT_LOAD = CW'(SOFT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic pll_s;
    logic sdram_s;
    logic ready_lost;

    rs_state_e     state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic          timeout_q, timeout_d;
    logic          rst_n_q,   rst_n_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_pll (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (PLL_READY),
        .q_o   (pll_s)
    );

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_sdram (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (SDRAM_READY),
        .q_o   (sdram_s)
    );

    assign ready_lost = !(pll_s && sdram_s);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_WAIT_PLL: begin
                if (pll_s) begin
                    state_d = ST_WAIT_SDRAM;
                end
            end
            ST_WAIT_SDRAM: begin
                if (!pll_s) begin
                    state_d = ST_WAIT_PLL;
                    cnt_d   = '0;
                end else if (sdram_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
                if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ready_lost) begin
                    state_d = ST_WAIT_PLL;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (ready_lost) begin
                    state_d = ST_WAIT_PLL;
                    cnt_d   = '0;
                end else if (SOFT_RESET_REQ) begin
                    state_d = ST_SOFT;
                    cnt_d   = SOFT_LOAD;
                end
            end
            ST_SOFT: begin
                // Readiness loss wins over finishing the soft pulse.
                if (ready_lost) begin
                    state_d = ST_WAIT_PLL;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!SOFT_RESET_REQ) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_WAIT_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tmo_d = '0;
        if (state_q == ST_WAIT_SDRAM && state_d == ST_WAIT_SDRAM) begin
            tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
        end
    end

    assign rst_n_d = (state_d == ST_RUN);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_WAIT_PLL;
            cnt_q     <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            rst_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            rst_n_q   <= rst_n_d;
        end
    end

    assign RESET_OUT_n = rst_n_q;
    assign STATE       = state_q;
    assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short hold/soft/timeout counts.
// Outputs are sampled 1 time unit after each rising edge.
module tb_reset_sequencer;

    logic       CLK;
    logic       RESET;
    logic       PLL_READY;
    logic       SDRAM_READY;
    logic       SOFT_RESET_REQ;
    logic       RESET_OUT_n;
    logic [2:0] STATE;
    logic       TIMEOUT;

    int n_assert = 0;
    int n_fail   = 0;
    int low;

    reset_sequencer #(
        .HOLD_CYCLES    (16),
        .SOFT_CYCLES    (8),
        .TIMEOUT_CYCLES (100),
        .SYNC_STAGES    (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .PLL_READY      (PLL_READY),
        .SDRAM_READY    (SDRAM_READY),
        .SOFT_RESET_REQ (SOFT_RESET_REQ),
        .RESET_OUT_n    (RESET_OUT_n),
        .STATE          (STATE),
        .TIMEOUT        (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        RESET          = 1'b1;
        PLL_READY      = 1'b1;
        SDRAM_READY    = 1'b1;
        SOFT_RESET_REQ = 1'b0;
        step(3);
        check("rst_state", int'(STATE), 0);
        check("rst_out_n", int'(RESET_OUT_n), 0);
        check("rst_timeout", int'(TIMEOUT), 0);

        // Power-up: both ready before edge 1.
        RESET = 1'b0;
        step(2);
        check("pu_e2_state", int'(STATE), 0);
        step();
        check("pu_e3_state", int'(STATE), 1);
        step();
        check("pu_e4_state", int'(STATE), 2);
        step(15);
        check("pu_e19_state", int'(STATE), 2);
        check("pu_e19_out", int'(RESET_OUT_n), 0);
        step();
        check("pu_e20_state", int'(STATE), 3);
        check("pu_e20_out", int'(RESET_OUT_n), 1);
        check("pu_timeout", int'(TIMEOUT), 0);

        // Single-cycle soft request.
        SOFT_RESET_REQ = 1'b1;
        step();
        SOFT_RESET_REQ = 1'b0;
        check("soft_state", int'(STATE), 4);
        low = (RESET_OUT_n == 1'b0) ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (RESET_OUT_n) break;
            low++;
        end
        check("soft_pulse_low", low, 8);

        // Request sampled high on 51 consecutive edges.
        low = 0;
        SOFT_RESET_REQ = 1'b1;
        repeat (51) begin
            step();
            if (!RESET_OUT_n) low++;
        end
        SOFT_RESET_REQ = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (RESET_OUT_n) break;
            low++;
        end
        check("soft_held_low", low, 51);
        check("soft_held_state", int'(STATE), 3);

        // One-cycle PLL drop in RUN.
        PLL_READY = 1'b0;
        step();
        PLL_READY = 1'b1;
        step();
        check("pll_drop_e1_out", int'(RESET_OUT_n), 1);
        step();
        check("pll_drop_e2_out", int'(RESET_OUT_n), 0);
        check("pll_drop_e2_state", int'(STATE), 0);
        step();
        check("pll_drop_e3_state", int'(STATE), 1);
        step();
        check("pll_drop_e4_state", int'(STATE), 2);
        step(15);
        check("pll_drop_e19_out", int'(RESET_OUT_n), 0);
        step();
        check("pll_drop_e20_out", int'(RESET_OUT_n), 1);
        check("pll_drop_e20_state", int'(STATE), 3);

        // Synchronized SDRAM loss lands on the edge that samples the request.
        SDRAM_READY = 1'b0;
        step(2);
        check("race_pre_state", int'(STATE), 3);
        SOFT_RESET_REQ = 1'b1;
        step();
        check("race_state", int'(STATE), 0);
        check("race_out", int'(RESET_OUT_n), 0);
        step();
        check("race_next_state", int'(STATE), 1);
        SOFT_RESET_REQ = 1'b0;
        SDRAM_READY    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (RESET_OUT_n) break;
            step();
        end
        check("race_recover_out", int'(RESET_OUT_n), 1);

        // Async reset in RUN drops the output without a clock edge.
        #2 RESET = 1'b1;
        #1;
        check("async_run_out", int'(RESET_OUT_n), 0);
        check("async_run_state", int'(STATE), 0);

        // Reset mid-HOLD, 14 edges in (hold counter at 5).
        step();
        RESET = 1'b0;
        step(14);
        check("hold_mid_state", int'(STATE), 2);
        #2 RESET = 1'b1;
        #1;
        check("hold_rst_state", int'(STATE), 0);
        check("hold_rst_out", int'(RESET_OUT_n), 0);
        step();
        RESET = 1'b0;
        step(19);
        check("rerun_e19_state", int'(STATE), 2);
        step();
        check("rerun_e20_out", int'(RESET_OUT_n), 1);

        // SDRAM late by 150 cycles: timeout flags but sequence completes.
        RESET       = 1'b1;
        SDRAM_READY = 1'b0;
        step();
        RESET = 1'b0;
        step(3);
        check("tmo_e3_state", int'(STATE), 1);
        check("tmo_e3_flag", int'(TIMEOUT), 0);
        step(99);
        check("tmo_e102_flag", int'(TIMEOUT), 0);
        step();
        check("tmo_e103_flag", int'(TIMEOUT), 1);
        check("tmo_e103_state", int'(STATE), 1);
        step(40);
        check("tmo_e143_flag", int'(TIMEOUT), 1);
        step(6);
        SDRAM_READY = 1'b1;
        step(18);
        check("tmo_late_e18_out", int'(RESET_OUT_n), 0);
        check("tmo_late_e18_state", int'(STATE), 2);
        step();
        check("tmo_late_e19_out", int'(RESET_OUT_n), 1);
        check("tmo_late_e19_state", int'(STATE), 3);
        check("tmo_sticky", int'(TIMEOUT), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
